// File: rtl/jsilicon_uart_pkg.sv
// rtl/jsilicon_uart_pkg.sv - shared UART framing constants and FSM state encodings
//
// Purpose:
//   Common definitions for both ends of the UART link, so that TX and RX agree
//   on baud rate, data width and state numbering.
// Contents:
//   UART_CLKS_PER_BIT : default clock cycles per bit (10 MHz / 115200)
//   UART_DATA_W       : data bits per frame
//   uart_state_e      : FSM states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
//   even_parity()     : even-parity bit for a data byte
// Ports: none (package).

package jsilicon_uart_pkg;

  localparam int UART_CLKS_PER_BIT = 87;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - valid/ready byte handshake between uart_rx and its consumer
//
// Purpose:
//   Groups the received-byte handshake of the UART receiver.
// Signals:
//   rx_data  : received byte, meaningful while rx_valid is high
//   rx_valid : holding register full
//   rx_ready : consumer accepts the byte (handshake on rx_valid & rx_ready)
// Modports:
//   master : receiver side (drives rx_data / rx_valid, samples rx_ready)
//   slave  : consumer side

interface uart_rx_if;
  import jsilicon_uart_pkg::*;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer and falling-edge detector for the rx line
//
// Purpose:
//   Brings the asynchronous serial line into the clock domain and flags the
//   high-to-low transitions that may mark a start bit.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-high reset; all flops reset to 1 (line idle)
//   i_rx   : raw asynchronous serial input
//   o_rx_s : synchronized line level
//   o_fall : high for one cycle after rx_s goes from 1 to 0

module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resetting to 1 matches the idle line, so leaving reset never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with holding register
//
// Purpose:
//   Recovers bytes from an asynchronous serial line, checks framing (and
//   optionally even parity), and hands good bytes to a consumer through a
//   one-entry holding register with a valid/ready handshake.
// Configuration macro:
//   UART_RX_PARITY_EN : defined -> 8E1 frame with PARITY state and live parity_err
//                       undefined -> 8N1 frame, parity_err tied to 0
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit (>= 4)
//   HALF_BIT     : counter terminal value for the start-bit mid sample
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high reset
//   ena        : receive enable; low aborts any frame in progress
//   rx         : raw serial line (idles high)
//   rx_if      : byte handshake (rx_data / rx_valid out, rx_ready in)
//   busy       : high whenever the FSM is not in IDLE
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, good byte dropped because holding register full

module uart_rx
  import jsilicon_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      ena,
  input  logic      rx,
  uart_rx_if.master rx_if,
  output logic      busy,
  output logic      frame_err,
  output logic      parity_err,
  output logic      overrun
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF     = CW'(HALF_BIT);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

  logic w_rx_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  uart_state_e            r_state,  w_state_nxt;
  logic [CW-1:0]          r_cnt,    w_cnt_nxt;
  logic [2:0]             r_idx,    w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift,  w_shift_nxt;
  logic [UART_DATA_W-1:0] r_data,   w_data_nxt;
  logic                   r_valid,  w_valid_nxt;
  logic                   r_busy,   w_busy_nxt;
  logic                   r_ferr,   w_ferr_nxt;
  logic                   r_ovr,    w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad, w_par_bad_nxt;
  logic                   r_perr,    w_perr_nxt;
`endif

  logic w_hs;
  logic w_bit_done;
  logic w_deliver;

  assign w_hs       = r_valid & rx_if.rx_ready;
  assign w_bit_done = (r_cnt == LP_BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_ferr    <= w_ferr_nxt;
      r_ovr     <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid & ~w_hs;
    w_ferr_nxt    = 1'b0;
    w_ovr_nxt     = 1'b0;
    w_deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr_nxt    = 1'b0;
`endif

    if (!ena) begin
      // Abort silently; the holding register keeps serving the consumer.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Only a fresh high-to-low edge starts a frame, so a line stuck
          // low after a framing error cannot retrigger.
          if (w_fall) begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = '0;
          end
        end

        ST_START: begin
          if (r_cnt == LP_HALF) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            // Line back high at mid start bit: treat as a glitch, no error.
            w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end

        ST_DATA: begin
          if (w_bit_done) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rx_s, r_shift[UART_DATA_W-1:1]};
            if (r_idx == 3'd7) begin
              w_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_done) begin
            w_cnt_nxt     = '0;
            w_par_bad_nxt = (w_rx_s != even_parity(r_shift));
            w_state_nxt   = ST_STOP;
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (w_bit_done) begin
            // Returning to IDLE at mid stop bit leaves half a bit of slack
            // for the next start edge.
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            if (!w_rx_s) begin
              w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              w_perr_nxt = 1'b1;
`endif
            end else begin
              w_deliver = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end

    // A same-cycle handshake frees the slot, so the new byte may replace the
    // one being consumed; otherwise a full register keeps its byte.
    if (w_deliver) begin
      if (!r_valid || w_hs) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign busy           = r_busy;
  assign frame_err      = r_ferr;
  assign overrun        = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = r_perr;
`else
  assign parity_err     = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the chip's 8N1 UART link, the receive end of the FSM core's `uart_tx` output. It recovers bytes from an asynchronous serial line, validates framing, and presents each byte through a one-entry holding register with a valid/ready handshake. The block sits beside the FSM core, fed from a spare `uio_in` pin. Received bytes can be written back into the register file or looped back to TX for self-test.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200). Must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (floor): cycles from the detected start edge to the start-bit mid-sample.

Ports (one clock domain; reset is asynchronous and active-high):
- `clock`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `ena`, input, 1: receive enable. Low aborts any frame in progress.
- `rx`, input, 1: raw serial line, asynchronous. Idles high.
- `rx_data`, output, 8: received byte, valid while `rx_valid` is high.
- `rx_valid`, output, 1: holding register full.
- `rx_ready`, input, 1: consumer accepts the byte; a handshake occurs on a cycle with `rx_valid & rx_ready`.
- `busy`, output, 1: high in every state except IDLE.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`, output, 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the holding register is full.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer whose flops reset to 1, producing `rx_s`. A registered copy of `rx_s` provides falling-edge detection.
- **State machine.** States are IDLE, START, DATA, PARITY (present only with the macro), and STOP. A baud counter and a 3-bit bit index support it.
- **IDLE.** A falling edge of `rx_s` while `ena` is high moves to START and loads the counter. A line held low never retriggers; a new high-to-low edge is required.
- **START.** After `HALF_BIT` cycles, sample `rx_s`. If it is 1, this is a false start: return to IDLE with no error. If it is 0, go to DATA.
- **DATA.** Sample every `CLKS_PER_BIT` cycles, shifting bits in LSB first. After bit index 7, go to PARITY or STOP.
- **PARITY.** Sample after `CLKS_PER_BIT` cycles and compare against the XOR of the 8 data bits (even parity). Go to STOP either way, latching the mismatch.
- **STOP.** Sample after `CLKS_PER_BIT` cycles, then always return to IDLE. Exactly one outcome applies:
  - Stop bit is 0: pulse `frame_err` and discard the byte.
  - Parity mismatch latched: pulse `parity_err` and discard the byte. `frame_err` takes priority when both occur.
  - Good byte: deliver it to the holding register (below).
- **Delivery into the holding register.**
  - If the register is empty, or a handshake occurs in the same cycle, load `rx_data` and hold or keep `rx_valid` high.
  - Otherwise keep the old byte and pulse `overrun`.
- **Holding register.** `rx_valid` clears on a handshake with no simultaneous delivery. `rx_data` does not change while `rx_valid` is high except through a same-cycle handshake-plus-delivery.
- **`ena` low.** The FSM is forced to IDLE, counters clear, and no error pulses are produced. The holding register and handshake keep working. Synchronizer flops keep running.
- **Reset.** Reset mid-frame abandons the frame; nothing is delivered.

## Timing
- **Reset values.**
  - `rx_data` = 8'h00; `rx_valid` = `busy` = `frame_err` = `parity_err` = `overrun` = 0.
  - FSM = IDLE; synchronizer flops = 1.
- **Latency.** Measured from the first rising edge that samples raw `rx` = 0, `rx_valid` rises exactly 3 + `HALF_BIT` + 9·`CLKS_PER_BIT` cycles later. Add `CLKS_PER_BIT` with parity enabled.
- **Error and overrun pulses** occur in the same cycle in which `rx_valid` would have risen.
- **Back-to-back frames.** IDLE is re-entered at mid stop bit, so a start edge as early as `CLKS_PER_BIT/2` after that sample is caught. Tolerated baud mismatch is ±4 %.
- **Handshake.** There is no combinational path from `rx_ready` to any output; all outputs are registered.

## Configuration
- Macro `UART_RX_PARITY_EN`.
  - Defined: frame is 8E1, the PARITY state exists, and `parity_err` is live.
  - Undefined: frame is 8N1, the PARITY state is removed, and `parity_err` is constant 0.

## Structure
- **Shared package `jsilicon_uart_pkg`.** Holds the state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), the default `CLKS_PER_BIT`, and the data width of 8. It is shared with the TX side so both ends agree on baud and framing.
- **Sub-module `uart_rx_sync`.** The 2-flop synchronizer plus falling-edge detector, outputting `rx_s` and `fall`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
1. **Single byte.** Drive 8'hA5 as an 8N1 frame with `rx_ready` = 1. `rx_data` = 8'hA5, `rx_valid` pulses for 1 cycle exactly 3 + 8 + 144 cycles after the start edge; no errors.
2. **Overrun.** Send 8'h3C then 8'hC3 with `rx_ready` = 0. `rx_data` stays 8'h3C, and `overrun` pulses once at the second byte's stop sample. Raising `rx_ready` afterwards clears `rx_valid`.
3. **Framing error.** Send 8'h55 with the stop bit 0, then hold the line low for 40 bits, then release. One `frame_err` pulse, no `rx_valid`, and no retrigger until a fresh edge arrives.
4. **False start.** Apply a 5-cycle low glitch. `busy` rises, then returns to IDLE at the mid-sample with no outputs. A following 8'h01 frame is received correctly.
5. **Abort and recover.** Deassert `ena` during bit 4 of a frame, and separately assert `reset` mid-frame. FSM returns to IDLE and no byte is delivered. A following 8'hFF is received correctly.
6. **Parity (with `UART_RX_PARITY_EN`).** Send 8'h07 with parity bit 1: delivered. Send 8'h07 with parity bit 0: one `parity_err` pulse and no delivery.
